lagarto_l15_req_buffer: RTL and testbench
=========================================

// Module: lagarto_l15_req_buffer
// PURPOSE
// - Request queue between the Lagarto core's L1.5 request stream and the OpenPiton L1.5 (transducer side).
// - Accepts core requests on a valid/ready handshake.
// - Presents them in order on an L1.5-style val / header_ack handshake.
// - Decouples core stalls from L1.5 back-pressure and exposes occupancy for the debug/PMU logic.
// PARAMETERS
// - DATA_W  192  flattened request payload width (header + address + store data)
// - DEPTH   4    queue entries; power of 2, >= 2
// PORTS
// - clk_i             in   1                    core clock
// - rst_ni            in   1                    asynchronous active-low reset
// - flush_i           in   1                    drop queued requests not yet presented to L1.5
// - req_val_i         in   1                    core request valid
// - req_data_i        in   DATA_W               core request payload
// - req_rdy_o         out  1                    buffer can accept a request this cycle
// - l15_val_o         out  1                    request valid towards L1.5
// - l15_data_o        out  DATA_W               request payload towards L1.5 (head entry)
// - l15_header_ack_i  in   1                    L1.5 accepted the presented request
// - occupancy_o       out  $clog2(DEPTH+1)      entries currently held
// - overflow_o        out  1                    sticky: push attempted while req_rdy_o low
// BEHAVIOUR
// - Reset (async, rst_ni low): count=0, rd/wr ptr=0, req_rdy_o=1, l15_val_o=0, occupancy_o=0, overflow_o=0.
//   - l15_data_o is don't-care while l15_val_o=0.
//   - Storage array is not reset.
// - Push: req_val_i & req_rdy_o at a rising edge writes req_data_i at wr_ptr; wr_ptr++ (mod DEPTH).
// - req_rdy_o = (count < DEPTH).
//   - Depends on registered count only: no same-cycle pop credit.
//   - When full, a simultaneous ack does not enable a push.
// - l15_val_o = (count != 0); l15_data_o = mem[rd_ptr].
// - Pop: l15_val_o & l15_header_ack_i at a rising edge; rd_ptr++ (mod DEPTH).
//   - header_ack while l15_val_o=0 is ignored.
// - Once asserted, l15_val_o stays high and l15_data_o stays stable until the ack edge.
// - Latency: push-to-l15_val_o is 1 cycle (registered). Back-to-back acks drain 1 entry per cycle.
// - Push and pop in the same cycle: count unchanged. Pointers wrap at DEPTH.
// - overflow_o sets on req_val_i & ~req_rdy_o and holds until reset. The dropped request is not stored.
// - Flush (flush_i high at an edge):
//   - Entries behind the head are discarded and any same-cycle push is discarded.
//   - A head already presented (count!=0) is kept, since L1.5 protocol forbids retracting val.
//   - Result: count = (count!=0 & ~pop) ? 1 : 0; wr_ptr = rd_ptr_next + count_next.
// - Flush with a same-cycle head ack leaves the queue empty.
// - Reset mid-operation discards all entries immediately; l15_val_o drops asynchronously.
// CONFIGURATION
// - Macro LAGARTO_L15_BUF_BYPASS_EN.
// - Defined: when count==0 and req_val_i=1, the request is forwarded combinationally.
//   - l15_val_o=1 and l15_data_o=req_data_i in the same cycle (0-cycle latency).
//   - If l15_header_ack_i is also high that cycle, nothing is written.
//   - Otherwise the request is written as head and presented from storage next cycle with identical data.
//   - Bypass with flush_i high: the request is not forwarded; l15_val_o=0 and nothing is written.
// - Undefined: no combinational path req_* -> l15_*; push-to-val latency is always 1 cycle.
// - All other rules are identical in both builds.
// TESTING
// - Fill/drain: DEPTH=4, push A,B,C,D with no ack.
//   - req_rdy_o=0 after 4th push; occupancy_o=4; l15_data_o=A.
//   - Then ack every cycle: A,B,C,D are presented in order, 1 per cycle; occupancy_o returns to 0.
// - Back-pressure: push 0x5A.., hold header_ack=0 for 10 cycles -> l15_val_o=1 and l15_data_o=0x5A.. stable all 10 cycles.
//   - Ack on cycle 11 -> l15_val_o=0 next cycle.
// - Full + ack: queue full, req_val_i=1 and ack in the same cycle.
//   - Push rejected; overflow_o=1 and stays 1; occupancy_o=3 next cycle.
// - Flush: 3 entries queued (head presented), flush_i=1 with no ack -> occupancy_o=1, head unchanged.
//   - Repeat with ack in the flush cycle -> occupancy_o=0, l15_val_o=0.
// - Wrap: 11 push/pop pairs with DEPTH=4 -> data order preserved across pointer wrap; occupancy_o never exceeds 1.
// - Bypass (macro defined): empty queue, push X with ack in the same cycle -> l15_val_o=1, l15_data_o=X that cycle; occupancy_o stays 0.
//   - Without the macro: l15_val_o rises 1 cycle after the push.

Source files
------------

// File: rtl/lagarto_l15_req_buffer_if.sv
// Purpose: bundles the core-side and L1.5-side request signals of the L1.5 request buffer.
// Ports (signals):
//   flush_i, req_val_i, req_data_i  - core side: flush and request valid/payload
//   req_rdy_o                       - buffer can accept a request this cycle
//   l15_val_o, l15_data_o           - request presented to L1.5 (head entry)
//   l15_header_ack_i                - L1.5 accepted the presented request
//   occupancy_o, overflow_o         - debug/PMU: entries held, sticky dropped-push flag
// Modports: slave = the buffer, master = the environment driving it.
interface lagarto_l15_req_buffer_if #(
  parameter int unsigned DATA_W = 192,
  parameter int unsigned DEPTH  = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic              flush_i;
  logic              req_val_i;
  logic [DATA_W-1:0] req_data_i;
  logic              req_rdy_o;
  logic              l15_val_o;
  logic [DATA_W-1:0] l15_data_o;
  logic              l15_header_ack_i;
  logic [CNT_W-1:0]  occupancy_o;
  logic              overflow_o;

  modport slave (
    input  flush_i, req_val_i, req_data_i, l15_header_ack_i,
    output req_rdy_o, l15_val_o, l15_data_o, occupancy_o, overflow_o
  );

  modport master (
    output flush_i, req_val_i, req_data_i, l15_header_ack_i,
    input  req_rdy_o, l15_val_o, l15_data_o, occupancy_o, overflow_o
  );
endinterface

// File: rtl/lagarto_l15_req_buffer.sv
// Purpose: in-order request queue between the Lagarto core request stream and the OpenPiton
//   L1.5. Core side is valid/ready, L1.5 side is val/header_ack. Once val is raised towards
//   L1.5 it is never retracted, so a flush keeps an already presented head entry.
// Ports:
//   clk_i   - core clock
//   rst_ni  - asynchronous active-low reset
//   bus     - lagarto_l15_req_buffer_if.slave (see interface file for the signal list)
// Configuration:
//   LAGARTO_L15_BUF_BYPASS_EN - when defined, a request arriving at an empty queue is forwarded
//   combinationally to L1.5 in the same cycle. Undefined (default): push-to-val is 1 cycle.
module lagarto_l15_req_buffer #(
  parameter int unsigned DATA_W = 192,
  parameter int unsigned DEPTH  = 4
) (
  input logic                       clk_i,
  input logic                       rst_ni,
  lagarto_l15_req_buffer_if.slave   bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr, w_rd_ptr_nxt;
  logic [PTR_W-1:0]  r_wr_ptr, w_wr_ptr_nxt;
  logic [CNT_W-1:0]  r_count, w_count_nxt;
  logic              r_overflow;

  logic w_empty, w_full, w_bypass, w_push, w_pop;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_W'(DEPTH));

`ifdef LAGARTO_L15_BUF_BYPASS_EN
  // Forward straight through when nothing is queued; a flush suppresses the forward.
  assign w_bypass       = w_empty & bus.req_val_i & ~bus.flush_i;
  assign bus.l15_data_o = w_empty ? bus.req_data_i : r_mem[r_rd_ptr];
`else
  assign w_bypass       = 1'b0;
  assign bus.l15_data_o = r_mem[r_rd_ptr];
`endif

  assign bus.req_rdy_o   = ~w_full;
  assign bus.l15_val_o   = ~w_empty | w_bypass;
  assign bus.occupancy_o = r_count;
  assign bus.overflow_o  = r_overflow;

  // Pop only ever retires a stored entry; a bypassed request acked in the same cycle is
  // simply never written.
  assign w_pop  = ~w_empty & bus.l15_header_ack_i;
  assign w_push = bus.req_val_i & ~w_full & ~bus.flush_i & ~(w_bypass & bus.l15_header_ack_i);

  always_comb begin
    w_rd_ptr_nxt = r_rd_ptr + PTR_W'(w_pop);
    w_count_nxt  = r_count;
    w_wr_ptr_nxt = r_wr_ptr;
    if (bus.flush_i) begin
      // Keep only a head that stays presented; rebuild wr_ptr right behind it.
      w_count_nxt  = (~w_empty & ~w_pop) ? CNT_W'(1) : '0;
      w_wr_ptr_nxt = w_rd_ptr_nxt + PTR_W'(w_count_nxt);
    end else begin
      w_count_nxt  = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      w_wr_ptr_nxt = r_wr_ptr + PTR_W'(w_push);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_rd_ptr <= w_rd_ptr_nxt;
      r_wr_ptr <= w_wr_ptr_nxt;
      r_count  <= w_count_nxt;
      if (bus.req_val_i & w_full) r_overflow <= 1'b1;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.req_data_i;
  end
endmodule

// File: tb/tb_lagarto_l15_req_buffer.sv
module tb_lagarto_l15_req_buffer;
  localparam int unsigned W = 192;
  localparam int unsigned D = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lagarto_l15_req_buffer_if #(.DATA_W(W), .DEPTH(D)) bus ();

  lagarto_l15_req_buffer #(.DATA_W(W), .DEPTH(D)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a plain FIFO of payloads plus the sticky overflow flag.
  logic [W-1:0] q[$];
  bit           m_ovf = 1'b0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd_data();
    logic [W-1:0] r;
    for (int i = 0; i < 6; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic idle_inputs();
    bus.req_val_i        = 1'b0;
    bus.req_data_i       = '0;
    bus.l15_header_ack_i = 1'b0;
    bus.flush_i          = 1'b0;
  endtask

  // One clock: drive at negedge, compare against the model, then advance the model at the edge.
  task automatic step(input logic v, input logic [W-1:0] d, input logic ack, input logic fl);
    bit           exp_rdy, exp_val, byp, pop, push_ok;
    logic [W-1:0] exp_data, h;
    int           sz;
    @(negedge clk);
    bus.req_val_i        = v;
    bus.req_data_i       = d;
    bus.l15_header_ack_i = ack;
    bus.flush_i          = fl;
    #1;
    sz      = q.size();
    exp_rdy = (sz < D);
`ifdef LAGARTO_L15_BUF_BYPASS_EN
    byp = (sz == 0) && v && !fl;
`else
    byp = 1'b0;
`endif
    exp_val  = (sz != 0) || byp;
    exp_data = (sz != 0) ? q[0] : d;
    chk("req_rdy", W'(bus.req_rdy_o), W'(exp_rdy));
    chk("l15_val", W'(bus.l15_val_o), W'(exp_val));
    chk("occupancy", W'(bus.occupancy_o), W'(sz));
    chk("overflow", W'(bus.overflow_o), W'(m_ovf));
    if (exp_val) chk("l15_data", bus.l15_data_o, exp_data);
    @(posedge clk);
    pop     = (sz != 0) && ack;
    push_ok = v && exp_rdy && !fl && !(byp && ack);
    if (v && !exp_rdy) m_ovf = 1'b1;
    if (fl) begin
      if (pop) q.delete();
      else if (sz != 0) begin
        h = q[0];
        q.delete();
        q.push_back(h);
      end
    end else begin
      if (pop) void'(q.pop_front());
      if (push_ok) q.push_back(d);
    end
    #1;
    idle_inputs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_l15_val", W'(bus.l15_val_o), W'(0));
    chk("rst_occupancy", W'(bus.occupancy_o), W'(0));
    chk("rst_req_rdy", W'(bus.req_rdy_o), W'(1));
    chk("rst_overflow", W'(bus.overflow_o), W'(0));
    q.delete();
    m_ovf = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [W-1:0] vals [4];
  logic [W-1:0] pat5a;
  logic [W-1:0] x;

  initial begin
    idle_inputs();
    repeat (2) @(negedge clk);
    #1;
    chk("init_l15_val", W'(bus.l15_val_o), W'(0));
    chk("init_occupancy", W'(bus.occupancy_o), W'(0));
    chk("init_req_rdy", W'(bus.req_rdy_o), W'(1));
    chk("init_overflow", W'(bus.overflow_o), W'(0));
    rst_n = 1'b1;

    // Fill / drain
    for (int i = 0; i < 4; i++) vals[i] = rnd_data();
    for (int i = 0; i < 4; i++) step(1'b1, vals[i], 1'b0, 1'b0);
    chk("fill_occupancy", W'(bus.occupancy_o), W'(4));
    chk("fill_req_rdy", W'(bus.req_rdy_o), W'(0));
    chk("fill_head", bus.l15_data_o, vals[0]);
    for (int i = 0; i < 4; i++) begin
      chk("drain_order", bus.l15_data_o, vals[i]);
      step(1'b0, '0, 1'b1, 1'b0);
    end
    chk("drain_occupancy", W'(bus.occupancy_o), W'(0));
    chk("drain_l15_val", W'(bus.l15_val_o), W'(0));

    // Back-pressure: head held stable for 10 cycles
    pat5a = {24{8'h5A}};
    step(1'b1, pat5a, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      chk("bp_l15_val", W'(bus.l15_val_o), W'(1));
      chk("bp_l15_data", bus.l15_data_o, pat5a);
      step(1'b0, '0, 1'b0, 1'b0);
    end
    step(1'b0, '0, 1'b1, 1'b0);
    chk("bp_val_after_ack", W'(bus.l15_val_o), W'(0));

    // Full + ack: push rejected, overflow sticky
    for (int i = 0; i < 4; i++) step(1'b1, vals[i], 1'b0, 1'b0);
    step(1'b1, rnd_data(), 1'b1, 1'b0);
    chk("fullack_occupancy", W'(bus.occupancy_o), W'(3));
    chk("fullack_overflow", W'(bus.overflow_o), W'(1));
    chk("fullack_head", bus.l15_data_o, vals[1]);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("overflow_sticky", W'(bus.overflow_o), W'(1));

    // Flush without ack keeps the presented head; flush with ack empties
    step(1'b0, '0, 1'b0, 1'b1);
    chk("flush_occupancy", W'(bus.occupancy_o), W'(1));
    chk("flush_head", bus.l15_data_o, vals[1]);
    step(1'b1, rnd_data(), 1'b0, 1'b0);
    step(1'b1, rnd_data(), 1'b0, 1'b0);
    chk("refill_occupancy", W'(bus.occupancy_o), W'(3));
    step(1'b1, rnd_data(), 1'b1, 1'b1);
    chk("flushack_occupancy", W'(bus.occupancy_o), W'(0));
    chk("flushack_l15_val", W'(bus.l15_val_o), W'(0));

    do_reset();

    // Wrap: 11 push/pop pairs, occupancy stays <= 1
    step(1'b1, rnd_data(), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, rnd_data(), 1'b1, 1'b0);
      chk("wrap_occ_le1", W'(bus.occupancy_o <= 1), W'(1));
    end
    step(1'b0, '0, 1'b1, 1'b0);
    chk("wrap_empty", W'(bus.occupancy_o), W'(0));

    // Push-to-val latency
    x = rnd_data();
`ifdef LAGARTO_L15_BUF_BYPASS_EN
    @(negedge clk);
    bus.req_val_i        = 1'b1;
    bus.req_data_i       = x;
    bus.l15_header_ack_i = 1'b1;
    #1;
    chk("byp_l15_val", W'(bus.l15_val_o), W'(1));
    chk("byp_l15_data", bus.l15_data_o, x);
    @(posedge clk);
    #1;
    idle_inputs();
    chk("byp_occupancy", W'(bus.occupancy_o), W'(0));
`else
    @(negedge clk);
    bus.req_val_i  = 1'b1;
    bus.req_data_i = x;
    #1;
    chk("lat_val_same_cycle", W'(bus.l15_val_o), W'(0));
    @(posedge clk);
    q.push_back(x);
    #1;
    idle_inputs();
    chk("lat_val_next_cycle", W'(bus.l15_val_o), W'(1));
    chk("lat_data_next_cycle", bus.l15_data_o, x);
    step(1'b0, '0, 1'b1, 1'b0);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      step(1'($urandom_range(0, 1)), rnd_data(), 1'($urandom_range(0, 9) < 6),
           1'($urandom_range(0, 19) == 0));
      if (i == 1000) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
